// File: rtl/id_issue_stage.sv
// ============================================================================
// id_issue_stage
//
// Decode/issue stage. It resolves the source operands from the register file
// or the forwarding network, detects data hazards, and holds one issued
// instruction in an issue register that EXE consumes with a valid/ready
// handshake. A small FSM sequences a syscall:
//   1. drain the pipe behind it
//   2. pulse sys_req to the simulator
//   3. spend one resume cycle
//   4. return to normal issue
//
// Build option:
//   ID_JR_FWD_EN  defined   : jr target uses the forwarded rs value.
//                 undefined : jr target is always rs_raw. Any valid forwarding
//                             match on rs stalls a jr, ready or not.
//
// Ports:
//   CLK, RESET             clock, asynchronous active-low reset
//   in_valid / in_ready    decoded instruction handshake
//   in_instr, in_pc        instruction word and PC
//   rs_idx, rt_idx         source register indices
//   dest_idx               destination register index
//   rs_raw, rt_raw         register-file read data
//   uses_rs, uses_rt,
//   reg_write, is_syscall,
//   is_jr                  decoded flags
//   fwd_valid/ready/reg/data
//                          forwarding sources; index 0 is the youngest
//   out_valid / out_ready  issue register handshake toward EXE
//   out_instr, out_pc, out_opa, out_opb, out_dest, out_reg_write
//                          issued instruction fields
//   jr_target, jr_target_valid
//                          resolved jump-register target (valid is a pulse)
//   sys_req                one-cycle syscall request pulse
//   want_freeze            fetch must hold its PC
//
// FSM states:
//   state     | meaning
//   ST_RUN    | normal issue
//   ST_DRAIN  | syscall issued, bubbles while older work drains
//   ST_SYS    | sys_req asserted for this single cycle
//   ST_RESUME | one quiet cycle before issue restarts
// ============================================================================
module id_issue_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_FWD     = 3,
    parameter int DRAIN_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [31:0]               in_pc,
    input  logic [REG_AW-1:0]         rs_idx,
    input  logic [REG_AW-1:0]         rt_idx,
    input  logic [REG_AW-1:0]         dest_idx,
    input  logic [DATA_W-1:0]         rs_raw,
    input  logic [DATA_W-1:0]         rt_raw,
    input  logic                      uses_rs,
    input  logic                      uses_rt,
    input  logic                      reg_write,
    input  logic                      is_syscall,
    input  logic                      is_jr,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_reg,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_pc,
    output logic [DATA_W-1:0]         out_opa,
    output logic [DATA_W-1:0]         out_opb,
    output logic [REG_AW-1:0]         out_dest,
    output logic                      out_reg_write,
    output logic [DATA_W-1:0]         jr_target,
    output logic                      jr_target_valid,
    output logic                      sys_req,
    output logic                      want_freeze
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SYS, ST_RESUME} state_t;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_DEPTH);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;

    logic [DATA_W-1:0] opa_res, opb_res, jr_res;
    logic              rs_hit, rs_rdy, rt_hit, rt_rdy;
    logic              jr_hz, hazard, accept;

    // Operand resolution. The loop runs from oldest to youngest so that the
    // lowest matching source index wins. Register 0 is hardwired to zero and
    // never matches.
    always_comb begin
        opa_res = rs_raw;
        opb_res = rt_raw;
        rs_hit  = 1'b0;
        rs_rdy  = 1'b1;
        rt_hit  = 1'b0;
        rt_rdy  = 1'b1;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && fwd_reg[k*REG_AW +: REG_AW] == rs_idx) begin
                opa_res = fwd_data[k*DATA_W +: DATA_W];
                rs_hit  = 1'b1;
                rs_rdy  = fwd_ready[k];
            end
            if (fwd_valid[k] && fwd_reg[k*REG_AW +: REG_AW] == rt_idx) begin
                opb_res = fwd_data[k*DATA_W +: DATA_W];
                rt_hit  = 1'b1;
                rt_rdy  = fwd_ready[k];
            end
        end
        if (rs_idx == '0) begin
            opa_res = '0;
            rs_hit  = 1'b0;
            rs_rdy  = 1'b1;
        end
        if (rt_idx == '0) begin
            opb_res = '0;
            rt_hit  = 1'b0;
            rt_rdy  = 1'b1;
        end
    end

`ifdef ID_JR_FWD_EN
    assign jr_res = opa_res;
    assign jr_hz  = 1'b0;
`else
    // Without the forwarded jr path, the target comes straight from the
    // register file. Any in-flight writer of rs therefore has to retire first.
    assign jr_res = rs_raw;
    assign jr_hz  = is_jr && rs_hit;
`endif

    // A jr always reads rs, even when the decoder does not flag uses_rs.
    assign hazard = in_valid && (((uses_rs || is_jr) && rs_hit && !rs_rdy) ||
                                 (uses_rt && rt_hit && !rt_rdy) || jr_hz);

    // RESET gates the handshake outputs so that they read 0 while reset is
    // held, even though the state register sits in ST_RUN during reset.
    assign in_ready = RESET && (state == ST_RUN) && !hazard &&
                      (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (accept && is_syscall) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = DRAIN_LD;
                end
            end
            ST_DRAIN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_SYS;
                    cnt_nxt   = '0;
                end
            end
            ST_SYS:    state_nxt = ST_RESUME;
            ST_RESUME: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        sys_req     = (state == ST_SYS);
        want_freeze = RESET && ((state == ST_DRAIN) || (state == ST_SYS) ||
                                ((state == ST_RUN) && in_valid && !in_ready));
    end

    // Issue register and jr target. The register loads on accept, holds while
    // EXE stalls a real instruction, and otherwise loads a bubble.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_valid       <= 1'b0;
            out_instr       <= '0;
            out_pc          <= '0;
            out_opa         <= '0;
            out_opb         <= '0;
            out_dest        <= '0;
            out_reg_write   <= 1'b0;
            jr_target       <= '0;
            jr_target_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid     <= 1'b1;
                out_instr     <= in_instr;
                out_pc        <= in_pc;
                out_opa       <= opa_res;
                out_opb       <= opb_res;
                out_dest      <= dest_idx;
                out_reg_write <= reg_write && !is_syscall && (dest_idx != '0);
            end else if (!out_valid || out_ready) begin
                out_valid     <= 1'b0;
                out_instr     <= '0;
                out_pc        <= '0;
                out_opa       <= '0;
                out_opb       <= '0;
                out_dest      <= '0;
                out_reg_write <= 1'b0;
            end
            jr_target_valid <= accept && is_jr;
            if (accept && is_jr)
                jr_target <= jr_res;
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;

    localparam int DATA_W      = 32;
    localparam int REG_AW      = 5;
    localparam int NUM_FWD     = 3;
    localparam int DRAIN_DEPTH = 4;

    logic                      CLK = 1'b0;
    logic                      RESET = 1'b0;
    logic                      in_valid, in_ready;
    logic [31:0]               in_instr, in_pc;
    logic [REG_AW-1:0]         rs_idx, rt_idx, dest_idx;
    logic [DATA_W-1:0]         rs_raw, rt_raw;
    logic                      uses_rs, uses_rt, reg_write, is_syscall, is_jr;
    logic [NUM_FWD-1:0]        fwd_valid, fwd_ready;
    logic [NUM_FWD*REG_AW-1:0] fwd_reg;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic                      out_valid, out_ready;
    logic [31:0]               out_instr, out_pc;
    logic [DATA_W-1:0]         out_opa, out_opb;
    logic [REG_AW-1:0]         out_dest;
    logic                      out_reg_write;
    logic [DATA_W-1:0]         jr_target;
    logic                      jr_target_valid, sys_req, want_freeze;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    id_issue_stage #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .DRAIN_DEPTH(DRAIN_DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .dest_idx(dest_idx),
        .rs_raw(rs_raw), .rt_raw(rt_raw),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .reg_write(reg_write),
        .is_syscall(is_syscall), .is_jr(is_jr),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_opa(out_opa), .out_opb(out_opb), .out_dest(out_dest),
        .out_reg_write(out_reg_write),
        .jr_target(jr_target), .jr_target_valid(jr_target_valid),
        .sys_req(sys_req), .want_freeze(want_freeze)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        rs_idx     = '0;
        rt_idx     = '0;
        dest_idx   = '0;
        rs_raw     = '0;
        rt_raw     = '0;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        reg_write  = 1'b0;
        is_syscall = 1'b0;
        is_jr      = 1'b0;
        fwd_valid  = '0;
        fwd_ready  = '1;
        fwd_reg    = '0;
        fwd_data   = '0;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        in_valid = 1'b1;
        RESET    = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%0h exp=0", in_ready);
        end
        checks++;
        if ({out_valid, out_reg_write, sys_req, want_freeze, jr_target_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {out_valid, out_reg_write, sys_req, want_freeze, jr_target_valid});
        end
        checks++;
        if ({out_instr, out_pc, out_opa, out_opb} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data got=%0h/%0h/%0h/%0h exp=0", out_instr, out_pc, out_opa, out_opb);
        end
        tick();
        RESET    = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fwd_priority;
        clear_inputs();
        in_valid  = 1'b1;
        in_instr  = 32'h0064_1820;
        in_pc     = 32'h0040_0000;
        rs_idx    = 5'd3;
        rt_idx    = 5'd4;
        dest_idx  = 5'd4;
        rs_raw    = 32'h0000_AAAA;
        rt_raw    = 32'h0000_0044;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        reg_write = 1'b1;
        fwd_valid = 3'b011;
        fwd_reg   = {5'd0, 5'd3, 5'd3};
        fwd_data  = {32'h33, 32'h22, 32'h11};
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_in_ready got=%0h exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_opa !== 32'h11) begin
            failures++;
            $display("FAIL fwd_opa_youngest got=%0h exp=11", out_opa);
        end
        checks++;
        if ({out_valid, out_reg_write, out_dest, out_opb, out_instr, out_pc} !==
            {1'b1, 1'b1, 5'd4, 32'h44, 32'h0064_1820, 32'h0040_0000}) begin
            failures++;
            $display("FAIL fwd_fields got v=%0h w=%0h d=%0h b=%0h i=%0h pc=%0h",
                     out_valid, out_reg_write, out_dest, out_opb, out_instr, out_pc);
        end
    endtask

    task automatic test_zero_reg;
        clear_inputs();
        in_valid  = 1'b1;
        in_instr  = 32'h0007_0020;
        in_pc     = 32'h0040_0004;
        rs_idx    = 5'd0;
        rt_idx    = 5'd7;
        dest_idx  = 5'd0;
        rs_raw    = 32'h0000_1234;
        rt_raw    = 32'h0000_5678;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        reg_write = 1'b1;
        fwd_valid = 3'b101;
        fwd_reg   = {5'd7, 5'd9, 5'd0};
        fwd_data  = {32'h77, 32'h99, 32'h55};
        tick();
        checks++;
        if (out_opa !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg_opa got=%0h exp=0", out_opa);
        end
        checks++;
        if (out_opb !== 32'h77) begin
            failures++;
            $display("FAIL oldest_fwd_opb got=%0h exp=77", out_opb);
        end
        checks++;
        if ({out_valid, out_reg_write} !== 2'b10) begin
            failures++;
            $display("FAIL dest0_reg_write got=%b exp=10", {out_valid, out_reg_write});
        end
    endtask

    task automatic test_bubble;
        clear_inputs();
        tick();
        checks++;
        if ({out_valid, out_reg_write, out_instr} !== 34'h0) begin
            failures++;
            $display("FAIL idle_bubble got v=%0h w=%0h i=%0h exp=0", out_valid, out_reg_write, out_instr);
        end
    endtask

    task automatic test_hazard;
        clear_inputs();
        in_valid  = 1'b1;
        in_instr  = 32'h00A5_3020;
        in_pc     = 32'h0040_0010;
        rs_idx    = 5'd5;
        rt_idx    = 5'd6;
        dest_idx  = 5'd6;
        rs_raw    = 32'h0000_0001;
        uses_rs   = 1'b1;
        reg_write = 1'b1;
        fwd_valid = 3'b001;
        fwd_reg   = {5'd0, 5'd0, 5'd5};
        fwd_data  = {32'h0, 32'h0, 32'h5555};
        fwd_ready = 3'b110;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if ({in_ready, want_freeze} !== 2'b01) begin
                failures++;
                $display("FAIL hazard_stall c=%0d got rdy=%0h frz=%0h exp rdy=0 frz=1", c, in_ready, want_freeze);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hazard_bubble c=%0d got=%0h exp=0", c, out_valid);
            end
        end
        fwd_ready = 3'b111;
        settle();
        checks++;
        if ({in_ready, want_freeze} !== 2'b10) begin
            failures++;
            $display("FAIL hazard_clear got rdy=%0h frz=%0h exp rdy=1 frz=0", in_ready, want_freeze);
        end
        tick();
        checks++;
        if ({out_valid, out_opa} !== {1'b1, 32'h5555}) begin
            failures++;
            $display("FAIL hazard_issue got v=%0h a=%0h exp v=1 a=5555", out_valid, out_opa);
        end
    endtask

    task automatic test_backpressure;
        clear_inputs();
        in_valid  = 1'b1;
        in_instr  = 32'h1111_1111;
        in_pc     = 32'h0040_0020;
        rs_idx    = 5'd1;
        rs_raw    = 32'hA1;
        uses_rs   = 1'b1;
        dest_idx  = 5'd1;
        reg_write = 1'b1;
        tick();
        in_instr  = 32'h2222_2222;
        in_pc     = 32'h0040_0024;
        rs_raw    = 32'hB1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready c=%0d got=%0h exp=0", c, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_instr, out_pc, out_opa, out_reg_write} !==
                {1'b1, 32'h1111_1111, 32'h0040_0020, 32'hA1, 1'b1}) begin
                failures++;
                $display("FAIL bp_hold c=%0d got v=%0h i=%0h pc=%0h a=%0h", c, out_valid, out_instr, out_pc, out_opa);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_instr, out_opa} !== {1'b1, 32'h2222_2222, 32'hB1}) begin
            failures++;
            $display("FAIL bp_release got v=%0h i=%0h a=%0h exp i=22222222 a=b1", out_valid, out_instr, out_opa);
        end
    endtask

    task automatic test_syscall;
        int  sys_cyc;
        int  rdy_cyc;
        int  sys_cnt;
        bit  freeze_ok;
        bit  bub_ok;
        clear_inputs();
        in_valid   = 1'b1;
        is_syscall = 1'b1;
        reg_write  = 1'b1;
        dest_idx   = 5'd2;
        in_instr   = 32'h0000_000C;
        in_pc      = 32'h0040_0030;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sys_accept got=%0h exp=1", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_instr, out_reg_write} !== {1'b1, 32'h0000_000C, 1'b0}) begin
            failures++;
            $display("FAIL sys_issue got v=%0h i=%0h w=%0h exp v=1 i=c w=0", out_valid, out_instr, out_reg_write);
        end
        in_pc     = 32'h0040_0034;
        sys_cyc   = -1;
        rdy_cyc   = -1;
        sys_cnt   = 0;
        freeze_ok = 1'b1;
        bub_ok    = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            settle();
            if (sys_req === 1'b1) begin
                sys_cnt++;
                sys_cyc = c;
            end
            if (in_ready === 1'b1 && rdy_cyc < 0) rdy_cyc = c;
            if (want_freeze !== (c <= 5)) freeze_ok = 1'b0;
            if (c >= 2 && out_valid !== 1'b0) bub_ok = 1'b0;
            if (c < 7) tick();
        end
        checks++;
        if (sys_cnt != 1 || sys_cyc != 5) begin
            failures++;
            $display("FAIL sys_req_pulse got cnt=%0d cyc=%0d exp cnt=1 cyc=5", sys_cnt, sys_cyc);
        end
        checks++;
        if (rdy_cyc != 7) begin
            failures++;
            $display("FAIL sys_resume_ready got cyc=%0d exp=7", rdy_cyc);
        end
        checks++;
        if (!freeze_ok || !bub_ok) begin
            failures++;
            $display("FAIL sys_drain_seq got freeze_ok=%0d bubbles_ok=%0d exp 1/1", freeze_ok, bub_ok);
        end
    endtask

    task automatic test_back_to_back;
        int sys_cyc;
        int sys_cnt;
        tick();
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h0040_0034}) begin
            failures++;
            $display("FAIL b2b_second_issue got v=%0h pc=%0h exp v=1 pc=400034", out_valid, out_pc);
        end
        in_valid = 1'b0;
        sys_cyc  = -1;
        sys_cnt  = 0;
        for (int c = 1; c <= 7; c++) begin
            settle();
            if (sys_req === 1'b1) begin
                sys_cnt++;
                sys_cyc = c;
            end
            if (c < 7) tick();
        end
        checks++;
        if (sys_cnt != 1 || sys_cyc != 5) begin
            failures++;
            $display("FAIL b2b_sys_req got cnt=%0d cyc=%0d exp cnt=1 cyc=5", sys_cnt, sys_cyc);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_back_to_run got=%0h exp=1", in_ready);
        end
    endtask

    task automatic test_jr;
        clear_inputs();
        in_valid  = 1'b1;
        is_jr     = 1'b1;
        uses_rs   = 1'b1;
        rs_idx    = 5'd31;
        rs_raw    = 32'hBFC0_0000;
        in_instr  = 32'h03E0_0008;
        in_pc     = 32'h0040_0040;
        fwd_valid = 3'b010;
        fwd_reg   = {5'd0, 5'd31, 5'd0};
        fwd_data  = {32'h0, 32'h0040_0100, 32'h0};
`ifdef ID_JR_FWD_EN
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL jr_fwd_accept got=%0h exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({jr_target_valid, jr_target} !== {1'b1, 32'h0040_0100}) begin
            failures++;
            $display("FAIL jr_fwd_target got v=%0h t=%0h exp v=1 t=400100", jr_target_valid, jr_target);
        end
`else
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if ({in_ready, want_freeze} !== 2'b01) begin
                failures++;
                $display("FAIL jr_raw_stall c=%0d got rdy=%0h frz=%0h exp rdy=0 frz=1", c, in_ready, want_freeze);
            end
            tick();
            checks++;
            if (jr_target_valid !== 1'b0) begin
                failures++;
                $display("FAIL jr_hazard_pulse c=%0d got=%0h exp=0", c, jr_target_valid);
            end
        end
        fwd_valid = 3'b000;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL jr_raw_accept got=%0h exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({jr_target_valid, jr_target} !== {1'b1, 32'hBFC0_0000}) begin
            failures++;
            $display("FAIL jr_raw_target got v=%0h t=%0h exp v=1 t=bfc00000", jr_target_valid, jr_target);
        end
`endif
        tick();
        checks++;
        if (jr_target_valid !== 1'b0) begin
            failures++;
            $display("FAIL jr_pulse_width got=%0h exp=0", jr_target_valid);
        end
    endtask

    task automatic test_reset_mid_drain;
        int sys_cnt;
        clear_inputs();
        in_valid   = 1'b1;
        is_syscall = 1'b1;
        in_instr   = 32'h0000_000C;
        in_pc      = 32'h0040_0050;
        tick();
        in_valid = 1'b0;
        settle();
        checks++;
        if ({want_freeze, out_valid} !== 2'b11) begin
            failures++;
            $display("FAIL mid_drain_pre got frz=%0h v=%0h exp 1/1", want_freeze, out_valid);
        end
        tick();
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if ({out_valid, want_freeze, sys_req, in_ready, out_reg_write, jr_target_valid} !== 6'b0 ||
            {out_instr, out_pc} !== 64'h0) begin
            failures++;
            $display("FAIL mid_drain_reset got v=%0h frz=%0h sys=%0h rdy=%0h i=%0h pc=%0h exp all 0",
                     out_valid, want_freeze, sys_req, in_ready, out_instr, out_pc);
        end
        tick();
        tick();
        RESET   = 1'b1;
        sys_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sys_req === 1'b1) sys_cnt++;
        end
        checks++;
        if (sys_cnt != 0) begin
            failures++;
            $display("FAIL post_reset_sys_req got cnt=%0d exp=0", sys_cnt);
        end
        checks++;
        if ({in_ready, want_freeze} !== 2'b10) begin
            failures++;
            $display("FAIL post_reset_run got rdy=%0h frz=%0h exp 1/0", in_ready, want_freeze);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwd_priority();
        test_zero_reg();
        test_bubble();
        test_hazard();
        test_backpressure();
        test_syscall();
        test_back_to_back();
        test_jr();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
